// File: rtl/dl_pkg.sv
// Shared types and default parameters for the download memory writer.
// Ownership FSM states plus the defaults for address width, FIFO depth and hold tail.
package dl_pkg;

  localparam int DL_ADDR_W      = 25;
  localparam int DL_FIFO_DEPTH  = 4;
  localparam int DL_HOLD_CYCLES = 16;

  typedef enum logic [2:0] {
    ST_CPU      = 3'd0,
    ST_WAIT_CPU = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_TAIL     = 3'd4
  } dl_state_e;

endpackage

// File: rtl/dl_fifo.sv
// Small synchronous FIFO with a combinational head; a push is taken when not full,
// or when full but popped in the same cycle. Pointers reset asynchronously.
module dl_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/dl_mem_writer.sv
// Buffers the download byte stream and replays it on the shared memory port, holding the
// CPU while a download is active or draining. Optional running checksum: DL_CHECKSUM_EN.
module dl_mem_writer
  import dl_pkg::*;
#(
  parameter int ADDR_W      = DL_ADDR_W,
  parameter int FIFO_DEPTH  = DL_FIFO_DEPTH,
  parameter int HOLD_CYCLES = DL_HOLD_CYCLES
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dl_downloading,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic              cpu_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic              mem_ack,
  output logic              cpu_hold,
  output logic              dl_overflow,
  output logic [15:0]       dl_checksum,
  output logic [2:0]        dbg_state
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  dl_state_e           state;
  dl_state_e           state_nxt;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic [ADDR_W+7:0]   fifo_head;
  logic                dl_req_q;
  logic                dl_we_q;
  logic [ADDR_W-1:0]   dl_addr_q;
  logic [7:0]          dl_din_q;
  logic [CNT_W-1:0]    tail_cnt;
  logic                owner_cpu;

  assign fifo_pop = (state == ST_ISSUE) && !fifo_empty;

  dl_fifo #(
    .W     (ADDR_W + 8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (dl_wr),
    .pop     (fifo_pop),
    .din     ({dl_addr, dl_data}),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CPU: begin
        if (dl_downloading || !fifo_empty)
          state_nxt = (cpu_req && !mem_ack) ? ST_WAIT_CPU : ST_ISSUE;
      end
      ST_WAIT_CPU: if (mem_ack) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (!fifo_empty)          state_nxt = ST_WAIT_ACK;
        else if (!dl_downloading) state_nxt = ST_TAIL;
      end
      ST_WAIT_ACK: if (mem_ack) state_nxt = ST_ISSUE;
      ST_TAIL: begin
        if (dl_downloading || !fifo_empty) state_nxt = ST_ISSUE;
        else if (tail_cnt <= CNT_W'(1))    state_nxt = ST_CPU;
      end
      default: state_nxt = ST_CPU;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_CPU;
      dl_req_q    <= 1'b0;
      dl_we_q     <= 1'b0;
      dl_addr_q   <= '0;
      dl_din_q    <= '0;
      tail_cnt    <= '0;
      dl_overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (fifo_pop) begin
        dl_req_q  <= 1'b1;
        dl_we_q   <= 1'b1;
        dl_addr_q <= fifo_head[ADDR_W+7:8];
        dl_din_q  <= fifo_head[7:0];
      end else if ((state == ST_WAIT_ACK) && mem_ack) begin
        dl_req_q <= 1'b0;
        dl_we_q  <= 1'b0;
      end
      if ((state == ST_ISSUE) && fifo_empty && !dl_downloading)
        tail_cnt <= CNT_W'(HOLD_CYCLES);
      else if ((state == ST_TAIL) && (tail_cnt != '0))
        tail_cnt <= tail_cnt - CNT_W'(1);
      if (dl_wr && fifo_full && !fifo_pop)
        dl_overflow <= 1'b1;
    end
  end

  // Memory port is a req/ack handshake: mem_req stays high with stable mem_we/addr/din
  // until the single-cycle mem_ack; the download side issues its next request no sooner
  // than the cycle after that ack.
  assign owner_cpu = (state == ST_CPU) || (state == ST_WAIT_CPU);
  assign mem_req   = owner_cpu ? cpu_req  : dl_req_q;
  assign mem_we    = owner_cpu ? cpu_we   : dl_we_q;
  assign mem_addr  = owner_cpu ? cpu_addr : dl_addr_q;
  assign mem_din   = owner_cpu ? cpu_din  : dl_din_q;
  assign cpu_ack   = owner_cpu && mem_ack;
  assign cpu_hold  = (state != ST_CPU);
  assign dbg_state = state;

`ifdef DL_CHECKSUM_EN
  logic        dl_prev_q;
  logic [15:0] csum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_prev_q <= 1'b0;
      csum_q    <= '0;
    end else begin
      dl_prev_q <= dl_downloading;
      if (dl_downloading && !dl_prev_q)
        csum_q <= '0;
      else if ((state == ST_WAIT_ACK) && mem_ack)
        csum_q <= csum_q + {8'h00, dl_din_q};
    end
  end

  assign dl_checksum = csum_q;
`else
  assign dl_checksum = '0;
`endif

endmodule

// File: tb/tb_dl_mem_writer.sv
// Directed bench for dl_mem_writer: expected download writes go into exp_q when driven,
// a negedge monitor pops and compares each new download request on the memory port.
module tb_dl_mem_writer;

  localparam int ADDR_W = 25;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              dl_downloading;
  logic              dl_wr;
  logic [ADDR_W-1:0] dl_addr;
  logic [7:0]        dl_data;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_din;
  logic              cpu_ack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic              mem_ack;
  logic              cpu_hold;
  logic              dl_overflow;
  logic [15:0]       dl_checksum;
  logic [2:0]        dbg_state;

  dl_mem_writer #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4), .HOLD_CYCLES(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .dl_downloading (dl_downloading),
    .dl_wr          (dl_wr),
    .dl_addr        (dl_addr),
    .dl_data        (dl_data),
    .cpu_req        (cpu_req),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_din        (cpu_din),
    .cpu_ack        (cpu_ack),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_ack        (mem_ack),
    .cpu_hold       (cpu_hold),
    .dl_overflow    (dl_overflow),
    .dl_checksum    (dl_checksum),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [ADDR_W+7:0] exp_q[$];

  // memory responder
  int ack_delay = 3;
  bit ack_block = 0;
  int wcnt = 0;
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        mem_ack = 1'b0;
        wcnt = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
        wcnt = 0;
      end else if (mem_req && !ack_block) begin
        wcnt++;
        if (wcnt >= ack_delay) mem_ack = 1'b1;
      end else begin
        wcnt = 0;
      end
    end
  end

  // monitor / scoreboard
  bit prev_dl   = 0;
  bit prev_hold = 0;
  int dl_wr_cnt = 0;
  int last_dl_cyc = 0;
  int last_ack_cyc = 0;
  int cpu_ack_cnt = 0;
  int cpu_ack_cyc = 0;
  int hold_fall_cyc = 0;
  always @(negedge clk) begin
    logic              cur_dl;
    logic [ADDR_W+7:0] exp_v;
    if (!reset_n) begin
      prev_dl   = 0;
      prev_hold = cpu_hold;
    end else begin
      cur_dl = mem_req && mem_we && cpu_hold;
      if (cur_dl && !prev_dl) begin
        dl_wr_cnt++;
        last_dl_cyc = cyc;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write got=%0h exp=none", {mem_addr, mem_din});
        end else begin
          exp_v = exp_q.pop_front();
          if ({mem_addr, mem_din} !== exp_v) begin
            bad++;
            $display("FAIL write_data got=%0h exp=%0h", {mem_addr, mem_din}, exp_v);
          end
        end
      end
      prev_dl = cur_dl;
      if (mem_ack) last_ack_cyc = cyc + 1;
      if (cpu_ack) begin
        cpu_ack_cnt++;
        cpu_ack_cyc = cyc + 1;
      end
      if (prev_hold && !cpu_hold) hold_fall_cyc = cyc;
      prev_hold = cpu_hold;
    end
  end

  // driver tasks
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d, input bit keep);
    dl_wr   = 1'b1;
    dl_addr = a;
    dl_data = d;
    if (keep) exp_q.push_back({a, d});
    tick();
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!cpu_hold && exp_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_timeout got=busy exp=idle (pending=%0d)", name, exp_q.size());
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  int base;
  int k;
  bit got_ack;

  initial begin
    reset_n = 1'b0;
    dl_downloading = 1'b0;
    dl_wr = 1'b0;
    dl_addr = '0;
    dl_data = '0;
    cpu_req = 1'b0;
    cpu_we = 1'b1;
    cpu_addr = 25'h0ABCDE;
    cpu_din = 8'h5A;
    repeat (3) tick();

    // reset state and CPU passthrough
    check("rst_mem_req", mem_req, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_overflow", dl_overflow, 0);
    check("rst_checksum", dl_checksum, 0);
    check("rst_state", dbg_state, 0);
    check("rst_pass_addr", mem_addr, 25'h0ABCDE);
    check("rst_pass_din", mem_din, 8'h5A);
    check("rst_pass_we", mem_we, 1);
    cpu_we = 1'b0;
    cpu_addr = '0;
    reset_n = 1'b1;
    tick();

    // single byte, latency and hold tail
    ack_delay = 3;
    base = dl_wr_cnt;
    dl_downloading = 1'b1;
    @(negedge clk);
    check("hold_before_seen", cpu_hold, 0);
    @(negedge clk);
    check("hold_rise", cpu_hold, 1);
    tick();
    k = cyc + 1;
    drive_byte(25'h000100, 8'hA5, 1);
    dl_wr = 1'b0;
    dl_downloading = 1'b0;
    wait_idle("single");
    check("single_latency", last_dl_cyc, k + 1);
    check("single_count", dl_wr_cnt - base, 1);
    check("hold_fall_delay", hold_fall_cyc - last_ack_cyc, 17);

    // back-to-back pair
    ack_delay = 4;
    base = dl_wr_cnt;
    dl_downloading = 1'b1;
    tick();
    tick();
    drive_byte(25'h0081BB, 8'h34, 1);
    drive_byte(25'h0081BC, 8'h82, 1);
    dl_wr = 1'b0;
    dl_downloading = 1'b0;
    wait_idle("pair");
    check("pair_count", dl_wr_cnt - base, 2);
    check("pair_overflow", dl_overflow, 0);

    // CPU read in flight when download starts
    ack_delay = 5;
    base = dl_wr_cnt;
    k = cpu_ack_cnt;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 25'h002000;
    tick();
    dl_downloading = 1'b1;
    drive_byte(25'h003000, 8'h11, 1);
    dl_wr = 1'b0;
    @(negedge clk);
    check("cpuwait_hold", cpu_hold, 1);
    check("cpuwait_addr", mem_addr, 25'h002000);
    check("cpuwait_no_dl", dl_wr_cnt - base, 0);
    got_ack = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cpu_ack_cnt != k) begin
        got_ack = 1;
        break;
      end
    end
    check("cpu_ack_seen", got_ack, 1);
    cpu_req = 1'b0;
    cpu_addr = '0;
    dl_downloading = 1'b0;
    wait_idle("cpu_then_dl");
    check("cpu_ack_once", cpu_ack_cnt - k, 1);
    check("dl_after_cpu_ack", last_dl_cyc > cpu_ack_cyc, 1);
    check("cpu_then_dl_count", dl_wr_cnt - base, 1);

    // overflow with ack withheld
    ack_delay = 1;
    ack_block = 1;
    base = dl_wr_cnt;
    dl_downloading = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 6; i++)
      drive_byte(25'h001000 + 25'(i), 8'h40 + 8'(i), i < 5);
    dl_wr = 1'b0;
    check("ovf_set", dl_overflow, 1);
    repeat (5) tick();
    check("ovf_one_in_flight", dl_wr_cnt - base, 1);
    ack_block = 0;
    repeat (3) tick();
    check("ovf_sticky", dl_overflow, 1);
    dl_downloading = 1'b0;
    wait_idle("ovf_drain");
    check("ovf_written", dl_wr_cnt - base, 5);
    check("ovf_sticky_end", dl_overflow, 1);

    // checksum
    ack_delay = 2;
    dl_downloading = 1'b1;
    tick();
    drive_byte(25'h000200, 8'hFF, 1);
    drive_byte(25'h000201, 8'hFF, 1);
    drive_byte(25'h000202, 8'h03, 1);
    dl_wr = 1'b0;
    dl_downloading = 1'b0;
    wait_idle("csum");
`ifdef DL_CHECKSUM_EN
    check("csum_sum", dl_checksum, 16'h0201);
    dl_downloading = 1'b1;
    tick();
    tick();
    check("csum_clear", dl_checksum, 0);
    dl_downloading = 1'b0;
    wait_idle("csum_clear");
`else
    check("csum_tied", dl_checksum, 0);
`endif

    // reset with bytes queued
    ack_block = 1;
    dl_downloading = 1'b1;
    tick();
    tick();
    drive_byte(25'h000300, 8'h01, 1);
    drive_byte(25'h000301, 8'h02, 1);
    drive_byte(25'h000302, 8'h03, 1);
    drive_byte(25'h000303, 8'h04, 1);
    dl_wr = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    check("rstmid_mem_req", mem_req, 0);
    check("rstmid_hold", cpu_hold, 0);
    check("rstmid_state", dbg_state, 0);
    check("rstmid_overflow", dl_overflow, 0);
    exp_q.delete();
    dl_downloading = 1'b0;
    ack_block = 0;
    tick();
    tick();
    reset_n = 1'b1;
    base = dl_wr_cnt;
    repeat (30) tick();
    check("rstmid_no_writes", dl_wr_cnt - base, 0);
    check("rstmid_hold_after", cpu_hold, 0);

    // reset released while download still active
    reset_n = 1'b0;
    dl_downloading = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    @(negedge clk);
    check("rst_reenter_hold", cpu_hold, 1);
    tick();
    dl_downloading = 1'b0;
    wait_idle("reenter");

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
